// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding and arithmetic helpers for the FIR MAC engine.
// Exports state_t, ACC_W(), rnd() (round half up + arithmetic shift) and clip().
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      DRAIN,
      OUT
   } state_t;

   // Products are 2*dsize wide; log2(taps) guard bits absorb the sum.
   function automatic int ACC_W(input int dsize, input int taps);
      return 2 * dsize + $clog2(taps);
   endfunction

   // Caller sign-extends the accumulator to 64 bits.
   function automatic logic signed [63:0] rnd(
      input logic signed [63:0] acc,
      input int                 shift
   );
      return (acc + (64'sd1 <<< (shift - 1))) >>> shift;
   endfunction

   function automatic logic signed [63:0] clip(
      input logic signed [63:0] v,
      input int                 dsize
   );
      logic signed [63:0] mx;
      logic signed [63:0] mn;
      mx = (64'sd1 <<< (dsize - 1)) - 64'sd1;
      mn = -(64'sd1 <<< (dsize - 1));
      if (v > mx) return mx;
      if (v < mn) return mn;
      return v;
   endfunction

endpackage

// File: rtl/fir_mac_engine_if.sv
// fir_mac_engine_if: coefficient-write, sample-in and result-out bundle.
// master drives coeff_we/addr/wdata, in_valid/in_data; slave drives the rest.
interface fir_mac_engine_if #(
   parameter int DSIZE = 16,
   parameter int TAPS  = 8
);
   localparam int KW = $clog2(TAPS);

   logic             coeff_we;
   logic [KW-1:0]    coeff_addr;
   logic [DSIZE-1:0] coeff_wdata;
   logic             coeff_err;
   logic             in_valid;
   logic             in_ready;
   logic [DSIZE-1:0] in_data;
   logic             out_valid;
   logic [DSIZE-1:0] out_data;
   logic             out_sat;

   modport master (
      output coeff_we, coeff_addr, coeff_wdata, in_valid, in_data,
      input  coeff_err, in_ready, out_valid, out_data, out_sat
   );

   modport slave (
      input  coeff_we, coeff_addr, coeff_wdata, in_valid, in_data,
      output coeff_err, in_ready, out_valid, out_data, out_sat
   );
endinterface

// File: rtl/fir_mac_engine_mac_pipe.sv
// mac_pipe: registered signed DSIZE x DSIZE multiply feeding an accumulator.
// Ports: clk, rst_n, clr_i (zero acc, squash product), en_i (issue), a_i, b_i, acc_o.
module mac_pipe
   import fir_pkg::*;
#(
   parameter int DSIZE = 16,
   parameter int TAPS  = 8
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   clr_i,
   input  logic                                   en_i,
   input  logic signed [DSIZE-1:0]                a_i,
   input  logic signed [DSIZE-1:0]                b_i,
   output logic signed [ACC_W(DSIZE, TAPS)-1:0]   acc_o
);
   localparam int AW = ACC_W(DSIZE, TAPS);

   logic signed [2*DSIZE-1:0] prod_q;
   logic                      pv_q;
   logic signed [AW-1:0]      acc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= '0;
         pv_q   <= 1'b0;
         acc_q  <= '0;
      end else begin
         pv_q <= en_i & ~clr_i;
         if (en_i)
            prod_q <= (2*DSIZE)'(a_i) * (2*DSIZE)'(b_i);
         // product lands one cycle after issue
         if (clr_i)
            acc_q <= '0;
         else if (pv_q)
            acc_q <= acc_q + AW'(prod_q);
      end
   end

   assign acc_o = acc_q;
endmodule

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: time-multiplexed FIR, one MAC serving all taps over TAPS cycles.
// Ports: clk, rst_n (async, active-low), bus (fir_mac_engine_if.slave).
module fir_mac_engine
   import fir_pkg::*;
#(
   parameter int DSIZE     = 16,
   parameter int TAPS      = 8,
   parameter int OUT_SHIFT = 15
) (
   input logic              clk,
   input logic              rst_n,
   fir_mac_engine_if.slave  bus
);
   localparam int            KW   = $clog2(TAPS);
   localparam int            AW   = ACC_W(DSIZE, TAPS);
   localparam logic [KW-1:0] KMAX = KW'(TAPS - 1);

   state_t           state_q;
   logic [KW-1:0]    k_q;
   logic [KW-1:0]    wptr_q;
   logic [KW-1:0]    rptr_q;
   logic [DSIZE-1:0] coeff_q [TAPS];
   logic [DSIZE-1:0] hist_q  [TAPS];
   logic [DSIZE-1:0] out_q;
   logic             out_valid_q;
   logic             out_sat_q;
   logic             coeff_err_q;

   logic              idle;
   logic              cwr;
   logic              accept;
   logic signed [AW-1:0] acc;
   logic signed [63:0]   rv;

   assign idle         = (state_q == IDLE);
   assign cwr          = idle & bus.coeff_we;
   // a coefficient write in IDLE takes precedence over a sample
   assign bus.in_ready = idle & ~bus.coeff_we;
   assign accept       = bus.in_valid & bus.in_ready;
   assign rv           = rnd(64'(acc), OUT_SHIFT);

   mac_pipe #(
      .DSIZE (DSIZE),
      .TAPS  (TAPS)
   ) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (accept),
      .en_i  (state_q == MAC),
      .a_i   (signed'(coeff_q[k_q])),
      .b_i   (signed'(hist_q[rptr_q])),
      .acc_o (acc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TAPS; i++) begin
            coeff_q[i] <= '0;
            hist_q[i]  <= '0;
         end
      end else begin
         if (cwr)
            coeff_q[bus.coeff_addr] <= bus.coeff_wdata;
         if (accept)
            hist_q[wptr_q] <= bus.in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         k_q         <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         out_sat_q   <= 1'b0;
         coeff_err_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         coeff_err_q <= bus.coeff_we & ~idle;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  k_q     <= '0;
                  rptr_q  <= wptr_q;
                  wptr_q  <= (wptr_q == KMAX) ? '0 : wptr_q + KW'(1);
                  state_q <= MAC;
               end
            end
            MAC: begin
               k_q    <= k_q + KW'(1);
               // walk back through history: x[n-k]
               rptr_q <= (rptr_q == '0) ? KMAX : rptr_q - KW'(1);
               if (k_q == KMAX)
                  state_q <= DRAIN;
            end
            DRAIN: state_q <= OUT;
            OUT: begin
               out_q       <= DSIZE'(clip(rv, DSIZE));
               out_sat_q   <= (clip(rv, DSIZE) != rv);
               out_valid_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_q;
   assign bus.out_sat   = out_sat_q;
   assign bus.coeff_err = coeff_err_q;
endmodule
